// File: rtl/rc4_pkg.sv
// Shared RC4 decrypt types: byte type, default message length and the PRGA state encoding.
package rc4_pkg;

   typedef logic [7:0] byte_t;

   localparam int MSG_LEN_DEFAULT = 32;

   typedef enum logic [4:0] {
      IDLE,
      INC_I,
      RD_SI,
      WT_SI,
      GET_SI,
      CALC_J,
      RD_SJ,
      WT_SJ,
      GET_SJ,
      WR_SI,
      WR_SJ,
      RD_F,
      WT_F,
      GET_F,
      RD_ROM,
      WT_ROM,
      GET_ROM,
      WR_RAM,
      NEXT_K,
      DONE
   } state_t;

endpackage

// File: rtl/decrypt_fsm_if.sv
// Memory-side bus of the decrypt engine: S memory, encrypted-message ROM and plaintext RAM.
interface decrypt_fsm_if;
   import rc4_pkg::*;

   byte_t s_address;
   byte_t s_data;
   logic  s_wren;
   byte_t s_q;
   byte_t rom_address;
   byte_t rom_q;
   byte_t ram_address;
   byte_t ram_data;
   logic  ram_wren;

   modport master (
      output s_address, s_data, s_wren, rom_address, ram_address, ram_data, ram_wren,
      input  s_q, rom_q
   );

   modport slave (
      input  s_address, s_data, s_wren, rom_address, ram_address, ram_data, ram_wren,
      output s_q, rom_q
   );

endinterface

// File: rtl/rc4_char_check.sv
// Combinational plaintext filter: legal bytes are lowercase a..z and space.
module rc4_char_check
   import rc4_pkg::*;
(
   input  byte_t i_char,
   output logic  o_legal
);

   assign o_legal = ((i_char >= 8'h61) && (i_char <= 8'h7A)) || (i_char == 8'h20);

endmodule

// File: rtl/decrypt_fsm.sv
// RC4 PRGA decrypt pass over a pre-permuted S memory; 18 cycles per byte, memories have 2-cycle read latency.
// Optional DECRYPT_VALID_CHECK_EN aborts the pass on the first non-text plaintext byte and clears key_valid.
module decrypt_fsm
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = MSG_LEN_DEFAULT
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   output logic          finish,
   output logic          key_valid,
   decrypt_fsm_if.master mem
);

   localparam byte_t K_LAST = byte_t'(MSG_LEN - 1);

   state_t r_state;
   state_t w_next;

   byte_t r_i;
   byte_t r_j;
   byte_t r_k;
   byte_t r_si;
   byte_t r_sj;
   byte_t r_f;
   byte_t r_p;
   logic  r_key_valid;

   byte_t w_plain;
   logic  w_legal;

   assign w_plain = r_f ^ mem.rom_q;

`ifdef DECRYPT_VALID_CHECK_EN
   rc4_char_check u_char_check (
      .i_char  (w_plain),
      .o_legal (w_legal)
   );
`else
   assign w_legal = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_i         <= '0;
         r_j         <= '0;
         r_k         <= '0;
         r_si        <= '0;
         r_sj        <= '0;
         r_f         <= '0;
         r_p         <= '0;
         r_key_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // Fresh indices every pass so back-to-back passes never share state
               if (start) begin
                  r_i         <= '0;
                  r_j         <= '0;
                  r_k         <= '0;
                  r_key_valid <= 1'b1;
               end
            end
            INC_I:   r_i  <= r_i + 8'd1;
            GET_SI:  r_si <= mem.s_q;
            CALC_J:  r_j  <= r_j + r_si;
            GET_SJ:  r_sj <= mem.s_q;
            GET_F:   r_f  <= mem.s_q;
            GET_ROM: begin
               r_p <= w_plain;
               if (!w_legal) begin
                  r_key_valid <= 1'b0;
               end
            end
            NEXT_K: begin
               if (r_k != K_LAST) begin
                  r_k <= r_k + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = INC_I;
         INC_I:   w_next = RD_SI;
         RD_SI:   w_next = WT_SI;
         WT_SI:   w_next = GET_SI;
         GET_SI:  w_next = CALC_J;
         CALC_J:  w_next = RD_SJ;
         RD_SJ:   w_next = WT_SJ;
         WT_SJ:   w_next = GET_SJ;
         GET_SJ:  w_next = WR_SI;
         WR_SI:   w_next = WR_SJ;
         WR_SJ:   w_next = RD_F;
         RD_F:    w_next = WT_F;
         WT_F:    w_next = GET_F;
         GET_F:   w_next = RD_ROM;
         RD_ROM:  w_next = WT_ROM;
         WT_ROM:  w_next = GET_ROM;
         GET_ROM: w_next = w_legal ? WR_RAM : DONE;
         WR_RAM:  w_next = NEXT_K;
         NEXT_K:  w_next = (r_k == K_LAST) ? DONE : INC_I;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Addresses are held through the wait and capture states so the memories see a stable bus
   always_comb begin
      mem.s_address   = '0;
      mem.s_data      = '0;
      mem.s_wren      = 1'b0;
      mem.rom_address = '0;
      mem.ram_address = '0;
      mem.ram_data    = '0;
      mem.ram_wren    = 1'b0;
      finish          = 1'b0;
      case (r_state)
         RD_SI, WT_SI, GET_SI: mem.s_address = r_i;
         RD_SJ, WT_SJ, GET_SJ: mem.s_address = r_j;
         WR_SI: begin
            mem.s_address = r_i;
            mem.s_data    = r_sj;
            mem.s_wren    = 1'b1;
         end
         WR_SJ: begin
            mem.s_address = r_j;
            mem.s_data    = r_si;
            mem.s_wren    = 1'b1;
         end
         RD_F, WT_F, GET_F:       mem.s_address   = r_si + r_sj;
         RD_ROM, WT_ROM, GET_ROM: mem.rom_address = r_k;
         WR_RAM: begin
            mem.ram_address = r_k;
            mem.ram_data    = r_p;
            mem.ram_wren    = 1'b1;
         end
         DONE:    finish = 1'b1;
         default: ;
      endcase
   end

   assign key_valid = r_key_valid;

endmodule

// File: tb/tb_decrypt_fsm.sv
// Bench for decrypt_fsm: synchronous memory models, RC4 reference model, table and random passes.
module tb_decrypt_fsm;
   import rc4_pkg::*;

   localparam int MSG_LEN = 32;
   localparam int PASS_GAP = 2 + 18 * MSG_LEN;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic start = 1'b0;
   logic finish;
   logic key_valid;

   decrypt_fsm_if mem_if ();

   decrypt_fsm #(.MSG_LEN(MSG_LEN)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .finish    (finish),
      .key_valid (key_valid),
      .mem       (mem_if)
   );

   always #5 clk = ~clk;

   // ---------------- memory models and event counters ----------------
   byte_t S_mem [256];
   byte_t S_load[256];
   byte_t rom   [256];
   byte_t ram   [256];
   int    ram_wr_cnt[256];
   int    s_wr_total, ram_wr_total, fin_cnt, fin_long, fin_a;
   int    cyc = 0;
   logic  load = 1'b0;
   logic  fin_d = 1'b0;
   byte_t s_a1, rom_a1;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      fin_d  <= finish;
      s_a1   <= mem_if.s_address;
      mem_if.s_q <= S_mem[s_a1];
      rom_a1 <= mem_if.rom_address;
      mem_if.rom_q <= rom[rom_a1];
      if (load) begin
         for (int x = 0; x < 256; x++) begin
            S_mem[x]      <= S_load[x];
            ram_wr_cnt[x] <= 0;
         end
         s_wr_total   <= 0;
         ram_wr_total <= 0;
         fin_cnt      <= 0;
         fin_long     <= 0;
      end else begin
         if (mem_if.s_wren) begin
            S_mem[mem_if.s_address] <= mem_if.s_data;
            s_wr_total <= s_wr_total + 1;
         end
         if (mem_if.ram_wren) begin
            ram[mem_if.ram_address]        <= mem_if.ram_data;
            ram_wr_cnt[mem_if.ram_address] <= ram_wr_cnt[mem_if.ram_address] + 1;
            ram_wr_total <= ram_wr_total + 1;
         end
         if (finish) begin
            fin_cnt <= fin_cnt + 1;
            fin_a   <= cyc;
            if (fin_d) fin_long <= fin_long + 1;
         end
      end
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   byte_t m_S[256];
   byte_t ks[256];
   byte_t exp_ram[256];
   int    exp_n_wr, exp_s_wr;
   logic  exp_kv;

   // Keystream of the first n PRGA steps starting from S_load; m_S holds S afterwards
   task automatic prga(input int n);
      byte_t i, j, t;
      m_S = S_load;
      i = 0;
      j = 0;
      for (int k = 0; k < n; k++) begin
         i = i + 8'd1;
         j = j + m_S[i];
         t = m_S[i];
         m_S[i] = m_S[j];
         m_S[j] = t;
         ks[k] = m_S[byte_t'(m_S[i] + m_S[j])];
      end
   endtask

   function automatic logic is_text(byte_t p);
      return (p >= 8'h61 && p <= 8'h7A) || p == 8'h20;
   endfunction

   task automatic build_expect();
      int steps;
      prga(MSG_LEN);
      exp_n_wr = MSG_LEN;
      exp_kv   = 1'b1;
`ifdef DECRYPT_VALID_CHECK_EN
      for (int k = 0; k < MSG_LEN && exp_n_wr == MSG_LEN; k++) begin
         if (!is_text(ks[k] ^ rom[k])) begin
            exp_n_wr = k;
            exp_kv   = 1'b0;
         end
      end
`endif
      for (int k = 0; k < exp_n_wr; k++) exp_ram[k] = ks[k] ^ rom[k];
      steps = (exp_n_wr == MSG_LEN) ? MSG_LEN : exp_n_wr + 1;
      prga(steps);
      exp_s_wr = 2 * steps;
   endtask

   task automatic rand_perm();
      byte_t t;
      int y;
      for (int x = 0; x < 256; x++) S_load[x] = byte_t'(x);
      for (int x = 255; x > 0; x--) begin
         y = $urandom_range(0, x);
         t = S_load[x];
         S_load[x] = S_load[y];
         S_load[y] = t;
      end
   endtask

   // Rom holding random legal text under the keystream of S_load; bad_k >= 0 plants 'A' there
   task automatic craft_rom(input int bad_k);
      int r;
      byte_t pt;
      prga(MSG_LEN);
      for (int k = 0; k < MSG_LEN; k++) begin
         r  = $urandom_range(0, 26);
         pt = (r == 26) ? 8'h20 : byte_t'(8'h61 + r);
         if (k == bad_k) pt = 8'h41;
         rom[k] = ks[k] ^ pt;
      end
   endtask

   task automatic do_load();
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_fin(input int target);
      int c = 0;
      while (fin_cnt < target && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk("finish_seen", fin_cnt, target);
   endtask

   task automatic run_pass(input bit mid_start);
      do_load();
      build_expect();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (mid_start) begin
         repeat (100) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_fin(1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_pass(input string name);
      int errs;
      for (int k = 0; k < exp_n_wr; k++)
         chk($sformatf("%s_ram[%0d]", name, k), ram[k], exp_ram[k]);
      errs = 0;
      for (int x = 0; x < 256; x++) if (S_mem[x] !== m_S[x]) errs++;
      chk({name, "_S_final_errs"}, errs, 0);
      errs = 0;
      for (int x = 0; x < 256; x++) if (ram_wr_cnt[x] != ((x < exp_n_wr) ? 1 : 0)) errs++;
      chk({name, "_ram_wr_map_errs"}, errs, 0);
      chk({name, "_s_writes"}, s_wr_total, exp_s_wr);
      chk({name, "_ram_writes"}, ram_wr_total, exp_n_wr);
      chk({name, "_finish_pulses"}, fin_cnt, 1);
      chk({name, "_finish_long"}, fin_long, 0);
      chk({name, "_key_valid"}, key_valid, exp_kv);
   endtask

   function automatic logic [63:0] out_bits();
      return {20'd0, finish, key_valid, mem_if.s_wren, mem_if.ram_wren, mem_if.s_address,
              mem_if.s_data, mem_if.rom_address, mem_if.ram_address, mem_if.ram_data};
   endfunction

   // ---------------- hand-derived vectors, identity S ----------------
   typedef struct {
      int    k;
      byte_t rom_b;
      byte_t ram_e;
      int    sa;
      byte_t sa_e;
      int    sb;
      byte_t sb_e;
   } vec_t;

   vec_t tbl[5];

   initial begin
      byte_t key[3];
      byte_t jj, t;
      int seen, gap_a;

      tbl[0] = '{0, 8'h63, 8'h61, 1, 8'h01,  2, 8'h02};
      tbl[1] = '{1, 8'h25, 8'h20, 2, 8'h03,  3, 8'h02};
      tbl[2] = '{2, 8'h64, 8'h63, 3, 8'h05,  5, 8'h02};
      tbl[3] = '{3, 8'h6C, 8'h61, 4, 8'h09,  9, 8'h04};
      tbl[4] = '{4, 8'h6F, 8'h62, 5, 8'h0B, 11, 8'h02};

      // reset state
      #2 reset_n = 1'b0;
      #1 chk("reset_outputs", out_bits(), 64'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      chk("reset_key_valid", key_valid, 1'b0);

      // table pass: identity S, watch each byte as it lands
      for (int x = 0; x < 256; x++) S_load[x] = byte_t'(x);
      craft_rom(-1);
      foreach (tbl[n]) rom[tbl[n].k] = tbl[n].rom_b;
      do_load();
      build_expect();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      foreach (tbl[n]) begin
         for (int c = 0; c < 200 && ram_wr_total < tbl[n].k + 1; c++) @(negedge clk);
         chk($sformatf("tbl%0d_ram", n), ram[tbl[n].k], tbl[n].ram_e);
         chk($sformatf("tbl%0d_S[%0d]", n, tbl[n].sa), S_mem[tbl[n].sa], tbl[n].sa_e);
         chk($sformatf("tbl%0d_S[%0d]", n, tbl[n].sb), S_mem[tbl[n].sb], tbl[n].sb_e);
      end
      wait_fin(1);
      repeat (3) @(negedge clk);
      check_pass("identity");

      // key 0x000249 scheduled in software, then a full pass
      key[0] = 8'h00; key[1] = 8'h02; key[2] = 8'h49;
      for (int x = 0; x < 256; x++) S_load[x] = byte_t'(x);
      jj = 0;
      for (int x = 0; x < 256; x++) begin
         jj = jj + S_load[x] + key[x % 3];
         t = S_load[x];
         S_load[x] = S_load[jj];
         S_load[jj] = t;
      end
      craft_rom(-1);
      run_pass(1'b0);
      check_pass("ksa");
      chk("ksa_s_writes_64", s_wr_total, 64);
      chk("ksa_ram_writes_32", ram_wr_total, 32);

      // random permutations and messages, one with a stray start mid-pass
      for (int r = 0; r < 4; r++) begin
         rand_perm();
         craft_rom(-1);
`ifndef DECRYPT_VALID_CHECK_EN
         if (r % 2 == 1) for (int k = 0; k < MSG_LEN; k++) rom[k] = byte_t'($urandom);
`endif
         run_pass(r == 2);
         check_pass($sformatf("rand%0d", r));
      end

      // start held across a whole pass: second pass must restart from zero after DONE
      rand_perm();
      craft_rom(-1);
      do_load();
      build_expect();
      @(negedge clk);
      start = 1'b1;
      wait_fin(1);
      for (int k = 0; k < MSG_LEN; k++) chk($sformatf("held1_ram[%0d]", k), ram[k], exp_ram[k]);
      gap_a = fin_a;
      S_load = m_S;
      craft_rom(-1);
      build_expect();
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_fin(1);
      start = 1'b0;
      chk("held_restart_gap", fin_a - gap_a, PASS_GAP);
      repeat (3) @(negedge clk);
      check_pass("held2");

      // reset during WR_SJ of byte 2
      rand_perm();
      craft_rom(-1);
      do_load();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int c = 0; c < 500 && seen < 5; c++) begin
         @(negedge clk);
         if (mem_if.s_wren) seen++;
      end
      @(negedge clk);
      chk("wrsj_reached", mem_if.s_wren, 1'b1);
      reset_n = 1'b0;
      #1 chk("midreset_outputs", out_bits(), 64'd0);
      repeat (3) @(negedge clk);
      chk("midreset_idle_outputs", out_bits(), 64'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("midreset_ram_writes", ram_wr_total, 2);
      chk("midreset_s_writes", s_wr_total, 5);
      S_load = S_mem;
      craft_rom(-1);
      run_pass(1'b0);
      check_pass("after_reset");

`ifdef DECRYPT_VALID_CHECK_EN
      // illegal plaintext at k=5 aborts the pass
      rand_perm();
      craft_rom(5);
      run_pass(1'b0);
      check_pass("badchar");
      chk("badchar_ram_writes_5", ram_wr_total, 5);
      chk("badchar_no_write_5", ram_wr_cnt[5], 0);
      chk("badchar_key_valid", key_valid, 1'b0);
      rand_perm();
      craft_rom(-1);
      run_pass(1'b0);
      check_pass("recover");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/decrypt_fsm.md
DECRYPT_FSM -- requirements
Module: decrypt_fsm

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32, giving the message length in bytes (1..256).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  begins a decrypt pass when sampled high in IDLE.
REQ-005 SHALL have port finish  output  1  one-cycle pulse when the pass ends.
REQ-006 SHALL have port s_address / s_data / s_wren  output  8/8/1  S-memory address, write data and write enable.
REQ-007 SHALL have port s_q  input  8  S-memory read data.
REQ-008 SHALL have port rom_address  output  8  encrypted-message ROM address.
REQ-009 SHALL have port rom_q  input  8  encrypted-message ROM read data.
REQ-010 SHALL have port ram_address / ram_data / ram_wren  output  8/8/1  decrypted-message RAM address, write data and write enable.
REQ-011 SHALL have port key_valid  output  1  the pass produced only legal plaintext (see REQ-025).

Function
REQ-012 SHALL implement the RC4 PRGA over the already-permuted S: i=j=0; then for k=0..MSG_LEN-1:
  - i=i+1; j=j+S[i]; swap S[i] and S[j];
  - f=S[S[i]+S[j]]; ram[k]=f XOR rom[k].
REQ-013 SHALL perform all i, j, index and sum arithmetic in 8 bits, wrapping modulo 256; k SHALL count 0..MSG_LEN-1.
REQ-014 SHALL treat all memories as synchronous: read data is sampled two cycles after the state that registers the address (address state, wait state, capture state).
REQ-015 SHALL use these states, in order: IDLE, INC_I, RD_SI, WT_SI, GET_SI, CALC_J, RD_SJ, WT_SJ, GET_SJ, WR_SI, WR_SJ, RD_F, WT_F, GET_F, RD_ROM, WT_ROM, GET_ROM, WR_RAM, NEXT_K, DONE.
REQ-016 SHALL leave IDLE for INC_I only when start=1; start SHALL be ignored in every other state.
REQ-017 SHALL write S[i] in WR_SI and S[j] in WR_SJ, asserting s_wren for exactly one cycle each; s_wren SHALL be 0 in all other states.
REQ-018 SHALL, when i==j, leave S unchanged after both writes.
REQ-019 SHALL assert ram_wren for exactly one cycle, in WR_RAM, with ram_address=k.
REQ-020 SHALL, in NEXT_K, go to DONE if k==MSG_LEN-1, else increment k and go to INC_I.
REQ-021 SHALL assert finish only in DONE, then return to IDLE on the next cycle.
REQ-022 SHALL clear i, j and k on every IDLE->INC_I transition so that back-to-back passes are independent.

Reset
REQ-023 SHALL, on reset_n low, immediately force state=IDLE and drive all outputs to 0, including finish, the write enables, the addresses, the data outputs and key_valid.
REQ-024 SHALL, on reset in the middle of a pass, abandon the pass with no further writes; S and RAM contents are then undefined and the next start begins afresh.

Configuration
REQ-025 With DECRYPT_VALID_CHECK_EN defined:
  - key_valid SHALL be set to 1 on start and held until the next start.
  - In GET_ROM, a plaintext byte outside 0x61..0x7A that is also not 0x20 SHALL skip WR_RAM, go directly to DONE and clear key_valid.
REQ-026 Without DECRYPT_VALID_CHECK_EN, key_valid SHALL be 1 from the first start onward, and every byte SHALL be written.

Structure
REQ-027 SHALL take the state enum, the MSG_LEN default and the byte typedef from the shared package rc4_pkg.
REQ-028 SHALL place the plaintext character check in sub-module rc4_char_check (combinational, 8-bit in, 1-bit legal out), instantiated only under DECRYPT_VALID_CHECK_EN.

Verification
REQ-029 Identity S (S[x]=x), rom[0]=0x63 -> after k=0: S[1]=1, ram[0]=0x61 (f=2).
REQ-030 Identity S, k=1 -> i=2, j=3, S[2]=3, S[3]=2, f=5; rom[1]=0x25 gives ram[1]=0x20.
REQ-031 Full MSG_LEN=32 pass against a software RC4 model for key 0x000249 -> all 32 RAM bytes match; finish high for exactly 1 cycle; 64 S writes and 32 RAM writes.
REQ-032 reset_n pulsed low during WR_SJ -> outputs 0 in the same cycle; state IDLE; no RAM write; a new start completes correctly.
REQ-033 start held high for the whole pass -> a second pass starts only after DONE->IDLE, with i, j and k restarted from 0.
REQ-034 With DECRYPT_VALID_CHECK_EN, plaintext byte 0x41 at k=5 -> ram[0..4] written, no write at 5, finish pulses, key_valid=0.
